// File: rtl/rom_access_sequencer_if.sv
// Request/response and cartridge memory bus signals of the ROM/SaveRAM access sequencer.
// The master modport is the requester/memory side; the slave modport is the sequencer.
interface rom_access_sequencer_if;
    logic        snes_req;
    logic        snes_we;
    logic        snes_writable;
    logic [23:0] snes_addr;
    logic [7:0]  snes_wdata;
    logic [7:0]  snes_rdata;
    logic        snes_done;
    logic        mcu_req;
    logic        mcu_we;
    logic [23:0] mcu_addr;
    logic [7:0]  mcu_wdata;
    logic [7:0]  mcu_rdata;
    logic        mcu_done;
    logic        busy;
    logic [22:0] MEM_ADDR;
    logic [15:0] MEM_DOUT;
    logic        MEM_DOE;
    logic [15:0] MEM_DIN;
    logic        MEM_CE_N;
    logic        MEM_OE_N;
    logic        MEM_WE_N;
    logic        MEM_BHE_N;
    logic        MEM_BLE_N;

    modport master (
        output snes_req, snes_we, snes_writable, snes_addr, snes_wdata,
        output mcu_req, mcu_we, mcu_addr, mcu_wdata, MEM_DIN,
        input  snes_rdata, snes_done, mcu_rdata, mcu_done, busy,
        input  MEM_ADDR, MEM_DOUT, MEM_DOE, MEM_CE_N, MEM_OE_N, MEM_WE_N, MEM_BHE_N, MEM_BLE_N
    );

    modport slave (
        input  snes_req, snes_we, snes_writable, snes_addr, snes_wdata,
        input  mcu_req, mcu_we, mcu_addr, mcu_wdata, MEM_DIN,
        output snes_rdata, snes_done, mcu_rdata, mcu_done, busy,
        output MEM_ADDR, MEM_DOUT, MEM_DOE, MEM_CE_N, MEM_OE_N, MEM_WE_N, MEM_BHE_N, MEM_BLE_N
    );
endinterface

// File: rtl/rom_access_sequencer.sv
// Arbitrates SNES (priority) and MCU byte accesses onto the 16-bit PSRAM/SRAM bus,
// sequencing CE/OE/WE/lane strobes with programmable cycle lengths; all outputs are registered.
module rom_access_sequencer #(
    parameter int RD_CYCLES      = 6,
    parameter int WR_CYCLES      = 5,
    parameter int RECOVER_CYCLES = 1
) (
    input  logic CLK2,
    input  logic RST,
    rom_access_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RECOVER = 2'd2} state_t;

    state_t      state_r, state_s;
    logic [3:0]  cnt_r, cnt_s;
    logic        snes_pend_r, snes_pend_s, snes_pend_in_s;
    logic        mcu_pend_r, mcu_pend_s, mcu_pend_in_s;
    logic [23:0] snes_addr_r, snes_addr_s, mcu_addr_r, mcu_addr_s;
    logic        snes_we_r, snes_we_s, mcu_we_r, mcu_we_s;
    logic [7:0]  snes_wdata_r, snes_wdata_s, mcu_wdata_r, mcu_wdata_s;
    logic        owner_r, owner_s;
    logic        we_r, we_s;
    logic        hi_r, hi_s;
    logic        pick_s, acc_s;
    logic [7:0]  lane_s;
    logic [22:0] mem_addr_r, mem_addr_s;
    logic [15:0] mem_dout_r, mem_dout_s;
    logic [7:0]  snes_rdata_r, snes_rdata_s, mcu_rdata_r, mcu_rdata_s;
    logic        snes_done_r, snes_done_s, mcu_done_r, mcu_done_s;
    logic        ce_n_r, oe_n_r, we_n_r, bhe_n_r, ble_n_r, doe_r, busy_r;

    // A request pulse counts as pending in the very clock it arrives and wins over the latched copy.
    assign snes_pend_in_s = snes_pend_r | bus.snes_req;
    assign mcu_pend_in_s  = mcu_pend_r | bus.mcu_req;
    assign snes_addr_s    = bus.snes_req ? bus.snes_addr : snes_addr_r;
    assign snes_we_s      = bus.snes_req ? (bus.snes_we & bus.snes_writable) : snes_we_r;
    assign snes_wdata_s   = bus.snes_req ? bus.snes_wdata : snes_wdata_r;
    assign mcu_addr_s     = bus.mcu_req ? bus.mcu_addr : mcu_addr_r;
    assign mcu_we_s       = bus.mcu_req ? bus.mcu_we : mcu_we_r;
    assign mcu_wdata_s    = bus.mcu_req ? bus.mcu_wdata : mcu_wdata_r;
    assign lane_s         = hi_r ? bus.MEM_DIN[15:8] : bus.MEM_DIN[7:0];

    // Next-state, arbitration and data-path decisions.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        snes_pend_s  = snes_pend_in_s;
        mcu_pend_s   = mcu_pend_in_s;
        owner_s      = owner_r;
        we_s         = we_r;
        hi_s         = hi_r;
        mem_addr_s   = mem_addr_r;
        mem_dout_s   = mem_dout_r;
        snes_rdata_s = snes_rdata_r;
        mcu_rdata_s  = mcu_rdata_r;
        snes_done_s  = 1'b0;
        mcu_done_s   = 1'b0;
        pick_s       = 1'b0;
        case (state_r)
            IDLE: pick_s = 1'b1;
            ACCESS: begin
                if (cnt_r == 4'd1) begin
                    if (!we_r && owner_r) begin
                        mcu_rdata_s = lane_s;
                    end else if (!we_r) begin
                        snes_rdata_s = lane_s;
                    end else begin
                        mcu_rdata_s = mcu_rdata_r;
                    end
                    snes_done_s = ~owner_r;
                    mcu_done_s  = owner_r;
                    if (RECOVER_CYCLES == 0) begin
                        state_s = IDLE;
                        cnt_s   = 4'd0;
                    end else begin
                        state_s = RECOVER;
                        cnt_s   = 4'(RECOVER_CYCLES);
                    end
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            RECOVER: begin
                // The last recovery clock doubles as the idle decision so CE stays high only RECOVER_CYCLES.
                if (cnt_r <= 4'd1) begin
                    state_s = IDLE;
                    cnt_s   = 4'd0;
                    pick_s  = 1'b1;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            default: state_s = IDLE;
        endcase
        if (pick_s && snes_pend_in_s) begin
            owner_s     = 1'b0;
            we_s        = snes_we_s;
            hi_s        = snes_addr_s[0];
            mem_addr_s  = snes_addr_s[23:1];
            mem_dout_s  = {snes_wdata_s, snes_wdata_s};
            snes_pend_s = 1'b0;
            state_s     = ACCESS;
            cnt_s       = snes_we_s ? 4'(WR_CYCLES) : 4'(RD_CYCLES);
        end else if (pick_s && mcu_pend_in_s) begin
            owner_s     = 1'b1;
            we_s        = mcu_we_s;
            hi_s        = mcu_addr_s[0];
            mem_addr_s  = mcu_addr_s[23:1];
            mem_dout_s  = {mcu_wdata_s, mcu_wdata_s};
            mcu_pend_s  = 1'b0;
            state_s     = ACCESS;
            cnt_s       = mcu_we_s ? 4'(WR_CYCLES) : 4'(RD_CYCLES);
        end else begin
            owner_s = owner_r;
        end
    end

    assign acc_s = (state_s == ACCESS);

    // State, latched requests and registered bus strobes derived from the next state.
    always_ff @(posedge CLK2 or posedge RST) begin
        if (RST) begin
            state_r      <= IDLE;
            cnt_r        <= 4'd0;
            snes_pend_r  <= 1'b0;
            mcu_pend_r   <= 1'b0;
            snes_addr_r  <= 24'd0;
            snes_we_r    <= 1'b0;
            snes_wdata_r <= 8'd0;
            mcu_addr_r   <= 24'd0;
            mcu_we_r     <= 1'b0;
            mcu_wdata_r  <= 8'd0;
            owner_r      <= 1'b0;
            we_r         <= 1'b0;
            hi_r         <= 1'b0;
            mem_addr_r   <= 23'd0;
            mem_dout_r   <= 16'd0;
            snes_rdata_r <= 8'd0;
            mcu_rdata_r  <= 8'd0;
            snes_done_r  <= 1'b0;
            mcu_done_r   <= 1'b0;
            ce_n_r       <= 1'b1;
            oe_n_r       <= 1'b1;
            we_n_r       <= 1'b1;
            bhe_n_r      <= 1'b1;
            ble_n_r      <= 1'b1;
            doe_r        <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            snes_pend_r  <= snes_pend_s;
            mcu_pend_r   <= mcu_pend_s;
            snes_addr_r  <= snes_addr_s;
            snes_we_r    <= snes_we_s;
            snes_wdata_r <= snes_wdata_s;
            mcu_addr_r   <= mcu_addr_s;
            mcu_we_r     <= mcu_we_s;
            mcu_wdata_r  <= mcu_wdata_s;
            owner_r      <= owner_s;
            we_r         <= we_s;
            hi_r         <= hi_s;
            mem_addr_r   <= mem_addr_s;
            mem_dout_r   <= mem_dout_s;
            snes_rdata_r <= snes_rdata_s;
            mcu_rdata_r  <= mcu_rdata_s;
            snes_done_r  <= snes_done_s;
            mcu_done_r   <= mcu_done_s;
            ce_n_r       <= ~acc_s;
            oe_n_r       <= ~(acc_s & ~we_s);
            we_n_r       <= ~(acc_s & we_s);
            bhe_n_r      <= ~(acc_s & hi_s);
            ble_n_r      <= ~(acc_s & ~hi_s);
            doe_r        <= acc_s & we_s;
            busy_r       <= (state_s != IDLE) | snes_pend_s | mcu_pend_s;
        end
    end

    assign bus.snes_rdata = snes_rdata_r;
    assign bus.snes_done  = snes_done_r;
    assign bus.mcu_rdata  = mcu_rdata_r;
    assign bus.mcu_done   = mcu_done_r;
    assign bus.busy       = busy_r;
    assign bus.MEM_ADDR   = mem_addr_r;
    assign bus.MEM_DOUT   = mem_dout_r;
    assign bus.MEM_DOE    = doe_r;
    assign bus.MEM_CE_N   = ce_n_r;
    assign bus.MEM_OE_N   = oe_n_r;
    assign bus.MEM_WE_N   = we_n_r;
    assign bus.MEM_BHE_N  = bhe_n_r;
    assign bus.MEM_BLE_N  = ble_n_r;
endmodule

// File: tb/tb_rom_access_sequencer.sv
// Directed scoreboard bench for rom_access_sequencer: expected completions are queued at
// request time and matched (owner, cycle, read byte) when a done pulse appears.
module tb_rom_access_sequencer;
    localparam int RD_LAT = 8;
    localparam int WR_LAT = 7;

    typedef struct {
        logic       owner;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic CLK2;
    logic RST;
    rom_access_sequencer_if bus();

    rom_access_sequencer #(.RD_CYCLES(6), .WR_CYCLES(5), .RECOVER_CYCLES(1)) dut (
        .CLK2(CLK2),
        .RST (RST),
        .bus (bus)
    );

    exp_t sb[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   oe_lo, we_lo, doe_hi, mcu_done_seen;
    int   ce_run, ce_seen_low, last_gap;
    int   n0;

    initial CLK2 = 1'b0;
    always #5 CLK2 = ~CLK2;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr_stats();
        oe_lo = 0; we_lo = 0; doe_hi = 0; mcu_done_seen = 0;
        ce_run = 0; ce_seen_low = 0; last_gap = -1;
    endtask

    task automatic push_exp(input logic owner, input logic [7:0] data, input int c);
        exp_t e;
        e.owner = owner; e.data = data; e.cyc = c;
        sb.push_back(e);
    endtask

    // One clock: sample 2 time units after the rising edge, drop request pulses, score completions.
    task automatic tick();
        exp_t e;
        @(posedge CLK2);
        #2;
        bus.snes_req = 1'b0;
        bus.mcu_req  = 1'b0;
        cyc++;
        if (!bus.MEM_OE_N) oe_lo++;
        if (!bus.MEM_WE_N) we_lo++;
        if (bus.MEM_DOE) doe_hi++;
        if (bus.mcu_done) mcu_done_seen++;
        if (bus.MEM_CE_N) begin
            ce_run++;
        end else begin
            if (ce_seen_low != 0 && ce_run > 0) last_gap = ce_run;
            ce_run = 0;
            ce_seen_low = 1;
        end
        if (bus.snes_done || bus.mcu_done) begin
            chk("done_expected", 32'(sb.size() != 0), 32'h1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("done_owner", 32'(bus.mcu_done), 32'(e.owner));
                chk("done_cycle", 32'(cyc), 32'(e.cyc));
                chk("rdata", 32'(e.owner ? bus.mcu_rdata : bus.snes_rdata), 32'(e.data));
            end
        end
    endtask

    task automatic wait_idle(input int max);
        int k = 0;
        while (bus.busy && k < max) begin
            tick();
            k++;
        end
        chk("idle_timeout", 32'(bus.busy), 32'h0);
    endtask

    task automatic snes_go(input logic [23:0] a, input logic w, input logic wr, input logic [7:0] d);
        bus.snes_req = 1'b1; bus.snes_addr = a; bus.snes_we = w;
        bus.snes_writable = wr; bus.snes_wdata = d;
    endtask

    task automatic mcu_go(input logic [23:0] a, input logic w, input logic [7:0] d);
        bus.mcu_req = 1'b1; bus.mcu_addr = a; bus.mcu_we = w; bus.mcu_wdata = d;
    endtask

    initial begin
        RST = 1'b1;
        bus.snes_req = 1'b0; bus.snes_we = 1'b0; bus.snes_writable = 1'b0;
        bus.snes_addr = 24'h0; bus.snes_wdata = 8'h0;
        bus.mcu_req = 1'b0; bus.mcu_we = 1'b0; bus.mcu_addr = 24'h0; bus.mcu_wdata = 8'h0;
        bus.MEM_DIN = 16'h0;
        clr_stats();
        tick(); tick();
        chk("rst_ce_n", 32'(bus.MEM_CE_N), 32'h1);
        chk("rst_oe_n", 32'(bus.MEM_OE_N), 32'h1);
        chk("rst_we_n", 32'(bus.MEM_WE_N), 32'h1);
        chk("rst_bhe_n", 32'(bus.MEM_BHE_N), 32'h1);
        chk("rst_ble_n", 32'(bus.MEM_BLE_N), 32'h1);
        chk("rst_doe", 32'(bus.MEM_DOE), 32'h0);
        chk("rst_addr", 32'(bus.MEM_ADDR), 32'h0);
        chk("rst_dout", 32'(bus.MEM_DOUT), 32'h0);
        chk("rst_snes_rdata", 32'(bus.snes_rdata), 32'h0);
        chk("rst_mcu_rdata", 32'(bus.mcu_rdata), 32'h0);
        chk("rst_dones", 32'({bus.snes_done, bus.mcu_done}), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        RST = 1'b0;
        tick();

        // SNES read, high lane; done is counted inclusively from the cycle req is high.
        bus.MEM_DIN = 16'hA55A;
        clr_stats(); n0 = cyc;
        snes_go(24'h400001, 1'b0, 1'b0, 8'h00);
        push_exp(1'b0, 8'hA5, n0 + RD_LAT - 1);
        tick();
        chk("rd_addr", 32'(bus.MEM_ADDR), 32'h200000);
        chk("rd_bhe_n", 32'(bus.MEM_BHE_N), 32'h0);
        chk("rd_ble_n", 32'(bus.MEM_BLE_N), 32'h1);
        chk("rd_ce_n", 32'(bus.MEM_CE_N), 32'h0);
        chk("rd_doe", 32'(bus.MEM_DOE), 32'h0);
        wait_idle(40);
        chk("rd_oe_len", 32'(oe_lo), 32'h6);
        chk("rd_we_len", 32'(we_lo), 32'h0);

        // SaveRAM write, low lane; snes_rdata must keep the previous read byte.
        clr_stats(); n0 = cyc;
        snes_go(24'hE00010, 1'b1, 1'b1, 8'h3C);
        push_exp(1'b0, 8'hA5, n0 + WR_LAT - 1);
        tick();
        chk("wr_dout", 32'(bus.MEM_DOUT), 32'h3C3C);
        chk("wr_addr", 32'(bus.MEM_ADDR), 32'h700008);
        chk("wr_ble_n", 32'(bus.MEM_BLE_N), 32'h0);
        chk("wr_bhe_n", 32'(bus.MEM_BHE_N), 32'h1);
        chk("wr_oe_n", 32'(bus.MEM_OE_N), 32'h1);
        wait_idle(40);
        chk("wr_we_len", 32'(we_lo), 32'h5);
        chk("wr_doe_len", 32'(doe_hi), 32'h5);
        chk("wr_oe_len", 32'(oe_lo), 32'h0);

        // Write to a protected address becomes a read.
        bus.MEM_DIN = 16'h1234;
        clr_stats(); n0 = cyc;
        snes_go(24'h000020, 1'b1, 1'b0, 8'h99);
        push_exp(1'b0, 8'h34, n0 + RD_LAT - 1);
        tick();
        wait_idle(40);
        chk("prot_we_len", 32'(we_lo), 32'h0);
        chk("prot_oe_len", 32'(oe_lo), 32'h6);
        chk("prot_doe_len", 32'(doe_hi), 32'h0);

        // Simultaneous requests: SNES first, one recovery clock, then MCU.
        bus.MEM_DIN = 16'hBEEF;
        clr_stats(); n0 = cyc;
        snes_go(24'h000003, 1'b0, 1'b1, 8'h00);
        mcu_go(24'h000100, 1'b0, 8'h00);
        push_exp(1'b0, 8'hBE, n0 + RD_LAT - 1);
        push_exp(1'b1, 8'hEF, n0 + RD_LAT - 1 + 7);
        tick();
        wait_idle(60);
        chk("sim_ce_gap", 32'(last_gap), 32'h1);
        chk("sim_oe_len", 32'(oe_lo), 32'd12);

        // Back-to-back SNES reads; busy falls only after the second recovery.
        bus.MEM_DIN = 16'h00C3;
        clr_stats(); n0 = cyc;
        snes_go(24'h000010, 1'b0, 1'b1, 8'h00);
        push_exp(1'b0, 8'hC3, n0 + 7);
        tick(); tick(); tick();
        snes_go(24'h000011, 1'b0, 1'b1, 8'h00);
        push_exp(1'b0, 8'h00, n0 + 14);
        while (cyc < n0 + 14) tick();
        chk("b2b_busy_recover", 32'(bus.busy), 32'h1);
        tick();
        chk("b2b_busy_idle", 32'(bus.busy), 32'h0);
        chk("b2b_ce_gap", 32'(last_gap), 32'h1);

        // MCU access is not aborted; late SNES request jumps ahead of a pending MCU request.
        bus.MEM_DIN = 16'h5AC3;
        clr_stats(); n0 = cyc;
        mcu_go(24'h000200, 1'b0, 8'h00);
        push_exp(1'b1, 8'hC3, n0 + 7);
        tick(); tick();
        snes_go(24'h000201, 1'b0, 1'b1, 8'h00);
        push_exp(1'b0, 8'h5A, n0 + 14);
        tick();
        mcu_go(24'h000203, 1'b0, 8'h00);
        push_exp(1'b1, 8'h5A, n0 + 21);
        tick();
        wait_idle(60);

        // Reset in the middle of an MCU write: strobes release at once, no done afterwards.
        clr_stats();
        mcu_go(24'h000300, 1'b1, 8'h77);
        tick(); tick(); tick();
        chk("mid_we_n", 32'(bus.MEM_WE_N), 32'h0);
        chk("mid_doe", 32'(bus.MEM_DOE), 32'h1);
        #1 RST = 1'b1;
        #1;
        chk("arst_ce_n", 32'(bus.MEM_CE_N), 32'h1);
        chk("arst_we_n", 32'(bus.MEM_WE_N), 32'h1);
        chk("arst_doe", 32'(bus.MEM_DOE), 32'h0);
        chk("arst_busy", 32'(bus.busy), 32'h0);
        tick(); tick();
        RST = 1'b0;
        mcu_done_seen = 0;
        repeat (12) tick();
        chk("arst_no_done", 32'(mcu_done_seen), 32'h0);
        chk("arst_mcu_rdata", 32'(bus.mcu_rdata), 32'h0);
        chk("arst_snes_rdata", 32'(bus.snes_rdata), 32'h0);

        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/rom_access_sequencer.md
Name: rom_access_sequencer

Overview:
- Services the memory requests that the SaveRAM/ROM address decoder produces: takes the decoded 24-bit byte address, the hit and writable flags, and runs the physical PSRAM/SRAM cycle on the 16-bit cartridge memory bus.
- Arbitrates SNES accesses against MCU accesses. SNES accesses have priority.
- Sequences CE/OE/WE/byte-lane strobes with programmable cycle lengths, latches read data, and returns it with a done pulse.

Parameters:
- RD_CYCLES, 6, clocks OE is held low for a read; data is sampled on the last of these cycles.
- WR_CYCLES, 5, clocks WE is held low for a write.
- RECOVER_CYCLES, 1, clocks CE is held high between consecutive accesses.

Ports:
- CLK2  in  1  system clock
- RST  in  1  asynchronous reset, active-high
- snes_req  in  1  one-clock pulse: SNES access start (already qualified by ROM_HIT)
- snes_we  in  1  1 = write; honoured only when snes_writable=1
- snes_writable  in  1  IS_WRITABLE from the decoder
- snes_addr  in  24  decoded byte address (ROM_ADDR from the decoder)
- snes_wdata  in  8  write byte
- snes_rdata  out  8  last SNES read byte
- snes_done  out  1  one-clock pulse: SNES access complete
- mcu_req  in  1  one-clock pulse: MCU access start
- mcu_we  in  1  1 = write
- mcu_addr  in  24  byte address
- mcu_wdata  in  8  write byte
- mcu_rdata  out  8  last MCU read byte
- mcu_done  out  1  one-clock pulse: MCU access complete
- busy  out  1  high whenever state is not IDLE or a request is pending
- MEM_ADDR  out  23  word address, equal to addr[23:1]
- MEM_DOUT  out  16  write data; the byte is replicated on both lanes
- MEM_DOE  out  1  data bus output enable
- MEM_DIN  in  16  read data
- MEM_CE_N, MEM_OE_N, MEM_WE_N, MEM_BHE_N, MEM_BLE_N  out  1 each  active-low strobes

Behaviour:
- Reset values:
  - All *_N strobes are 1. MEM_DOE=0. MEM_ADDR=0, MEM_DOUT=0.
  - snes_rdata=0, mcu_rdata=0. Both done outputs are 0. busy=0.
  - Both pending flags are cleared and state=IDLE.
- Reset mid-access: all strobes return to inactive immediately (asynchronous). No done pulse is issued for the aborted access.
- Request capture:
  - A req pulse sets the matching pending flag and latches that requester's addr, we and wdata in the same clock.
  - A second req from the same requester while its flag is still set overwrites the latched values; the last request wins.
  - snes_we is latched as snes_we & snes_writable. A write to a non-writable SNES address is therefore performed as a read: no WE is asserted, and snes_done still pulses.
- States: IDLE, ACCESS, RECOVER.
- IDLE:
  - If snes pending: select SNES. Else if mcu pending: select MCU.
  - On selection, in the same edge: go to ACCESS, load counter = RD_CYCLES or WR_CYCLES, drive MEM_ADDR, and clear the selected pending flag.
  - A req arriving in the same clock that IDLE is evaluated is seen as pending. SNES wins a simultaneous req pulse.
- ACCESS:
  - CE_N=0.
  - Read: OE_N=0, MEM_DOE=0.
  - Write: WE_N=0, MEM_DOE=1.
  - Byte lanes: addr[0]=0 selects the low lane (BLE_N=0, BHE_N=1); addr[0]=1 selects the high lane (BHE_N=0, BLE_N=1).
  - The counter decrements each clock. When counter=1:
    - Read: latch the selected lane of MEM_DIN into the owner's rdata register.
    - Pulse the owner's done on the next clock.
    - Go to RECOVER with counter=RECOVER_CYCLES.
- RECOVER:
  - All strobes inactive and MEM_DOE=0. Counter decrements; at 1 go to IDLE.
  - With RECOVER_CYCLES=0, RECOVER is skipped.
- Preemption: an MCU access in ACCESS is never aborted. A SNES req arriving during it is served next, ahead of any pending MCU request.
- Latency from req to done, idle bus, defaults: read 1+6+1 = 8 clocks; write 7 clocks.
- rdata holds its value until the next read by the same owner.
- busy = (state!=IDLE) | snes_pending | mcu_pending.
- Counters are 4 bits wide; parameters must be 1..15 (RECOVER_CYCLES may be 0).

Test Plan:
- Reset values: assert RST mid-write → CE_N/WE_N go to 1 asynchronously, MEM_DOE=0, and no mcu_done pulse after release.
- SNES read: snes_addr=24'h400001, MEM_DIN=16'hA55A → MEM_ADDR=23'h200000, BHE_N=0, BLE_N=1, OE_N low for 6 clocks; snes_rdata=8'hA5 and snes_done pulses 8 clocks after snes_req.
- SaveRAM write: snes_addr=24'hE00010, snes_we=1, snes_writable=1, wdata=8'h3C → MEM_DOUT=16'h3C3C, BLE_N=0, WE_N low for 5 clocks, MEM_DOE high for the same 5 clocks.
- Protected write: snes_we=1, snes_writable=0 → no WE_N assertion, OE_N cycle performed, snes_done pulses.
- Simultaneous requests: snes_req and mcu_req in the same clock → SNES access first, then RECOVER (1 clock), then the MCU access. mcu_done follows snes_done by 7 clocks for two reads.
- Back-to-back SNES: second snes_req during the first ACCESS → both serviced in order; CE_N high for exactly 1 clock between them; two snes_done pulses; busy deasserts only after the second access's RECOVER.
